// File: rtl/cdb_broadcast_pkg.sv
// CDB shared types: geometry constants, ROB entry and CDB packet.
// No ports; imported by the interface, the FIFO and the top.
package cdb_broadcast_pkg;

  localparam int NUM_FU    = 4;
  localparam int WAYS      = 2;
  localparam int ROB       = 32;
  localparam int PRF       = 64;
  localparam int XLEN      = 32;
  localparam int SRC_DEPTH = 2;

  localparam int ROB_W = $clog2(ROB);
  localparam int PRN_W = $clog2(PRF);
  localparam int FU_W  =
    (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  localparam int CDB_WAYS = WAYS;

  typedef struct packed {
    logic             complete;
    logic [PRN_W-1:0] PRN;
    logic             reg_write;
    logic             direction;
    logic [XLEN-1:0]  target;
  } rob_entry_t;

  typedef struct packed {
    logic [ROB_W-1:0] ROB_idx;
    logic [PRN_W-1:0] PRN;
    logic             reg_write;
    logic [XLEN-1:0]  value;
    logic             direction;
    logic [XLEN-1:0]  target;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_broadcast_if.sv
// FU completion inputs (valid/ready) and CDB broadcast outputs.
// master: FU side + CDB consumers; slave: cdb_broadcast.
interface cdb_broadcast_if;
  import cdb_broadcast_pkg::*;

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0]            fu_ready;
  logic [NUM_FU-1:0][ROB_W-1:0] fu_ROB_idx;
  logic [NUM_FU-1:0][PRN_W-1:0] fu_PRN;
  logic [NUM_FU-1:0]            fu_reg_write;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]            fu_direction;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_target;

  logic [CDB_WAYS-1:0]            CDB_valid;
  logic [CDB_WAYS-1:0][ROB_W-1:0] CDB_ROB_idx;
  logic [CDB_WAYS-1:0][PRN_W-1:0] CDB_PRN;
  logic [CDB_WAYS-1:0]            CDB_reg_write;
  logic [CDB_WAYS-1:0][XLEN-1:0]  CDB_value;
  logic [CDB_WAYS-1:0]            CDB_direction;
  logic [CDB_WAYS-1:0][XLEN-1:0]  CDB_target;

  modport master (
    output fu_valid, fu_ROB_idx, fu_PRN,
    output fu_reg_write, fu_value,
    output fu_direction, fu_target,
    input  fu_ready,
    input  CDB_valid, CDB_ROB_idx, CDB_PRN,
    input  CDB_reg_write, CDB_value,
    input  CDB_direction, CDB_target
  );

  modport slave (
    input  fu_valid, fu_ROB_idx, fu_PRN,
    input  fu_reg_write, fu_value,
    input  fu_direction, fu_target,
    output fu_ready,
    output CDB_valid, CDB_ROB_idx, CDB_PRN,
    output CDB_reg_write, CDB_value,
    output CDB_direction, CDB_target
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source completion FIFO; flush clears it, push when full drops.
// Ports: clock, reset, flush, push, pop, din, full, empty, head.
module cdb_src_fifo
  import cdb_broadcast_pkg::*;
#(
  parameter int DEPTH = SRC_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  cdb_packet_t din,
  output logic        full,
  output logic        empty,
  output cdb_packet_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  cdb_packet_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cdb_broadcast.sv
// CDB transmit: per-FU FIFOs, round-robin pack into WAYS registered slots.
// Ports: clock, reset (async low), proc_nuke, bus (cdb_broadcast_if.slave).
module cdb_broadcast
  import cdb_broadcast_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           proc_nuke,
  cdb_broadcast_if.slave bus
);

  cdb_packet_t       fu_pkt [NUM_FU];
  cdb_packet_t       head   [NUM_FU];
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] pop;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_src
    assign fu_pkt[i] = '{
      ROB_idx:   bus.fu_ROB_idx[i],
      PRN:       bus.fu_PRN[i],
      reg_write: bus.fu_reg_write[i],
      value:     bus.fu_value[i],
      direction: bus.fu_direction[i],
      target:    bus.fu_target[i]
    };

    cdb_src_fifo #(.DEPTH(SRC_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (proc_nuke),
      .push  (bus.fu_valid[i]),
      .pop   (pop[i]),
      .din   (fu_pkt[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  assign bus.fu_ready = ~full;

  logic [FU_W-1:0]     rr_ptr;
  logic [FU_W-1:0]     rr_nxt;
  logic [FU_W-1:0]     last;
  logic [FU_W-1:0]     idx;
  logic [FU_W:0]       sum;
  logic                placed;
  logic [CDB_WAYS-1:0] slot_vld;
  cdb_packet_t         slot_pkt [CDB_WAYS];

  // Each source in scan order takes the lowest free slot, if any.
  always_comb begin
    pop      = '0;
    slot_vld = '0;
    last     = rr_ptr;
    idx      = '0;
    sum      = '0;
    placed   = 1'b0;
    for (int w = 0; w < CDB_WAYS; w++) slot_pkt[w] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + (FU_W+1)'(k);
      if (sum >= (FU_W+1)'(NUM_FU))
        sum = sum - (FU_W+1)'(NUM_FU);
      idx    = sum[FU_W-1:0];
      placed = 1'b0;
      for (int w = 0; w < CDB_WAYS; w++) begin
        if (!empty[idx] && !placed && !slot_vld[w]) begin
          slot_vld[w] = 1'b1;
          slot_pkt[w] = head[idx];
          pop[idx]    = 1'b1;
          last        = idx;
          placed      = 1'b1;
        end
      end
    end
  end

  assign rr_nxt = (last == FU_W'(NUM_FU - 1)) ?
                  '0 : last + FU_W'(1);

  cdb_packet_t         cdb_q [CDB_WAYS];
  logic [CDB_WAYS-1:0] cdb_vld_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cdb_vld_q <= '0;
      for (int w = 0; w < CDB_WAYS; w++) cdb_q[w] <= '0;
    end else if (proc_nuke) begin
      rr_ptr    <= '0;
      cdb_vld_q <= '0;
      for (int w = 0; w < CDB_WAYS; w++) cdb_q[w] <= '0;
    end else begin
      if (|pop) rr_ptr <= rr_nxt;
      cdb_vld_q <= slot_vld;
      for (int w = 0; w < CDB_WAYS; w++)
        cdb_q[w] <= slot_pkt[w];
    end
  end

  assign bus.CDB_valid = cdb_vld_q;

  for (genvar w = 0; w < CDB_WAYS; w++) begin : g_out
    assign bus.CDB_ROB_idx[w]   = cdb_q[w].ROB_idx;
    assign bus.CDB_PRN[w]       = cdb_q[w].PRN;
    assign bus.CDB_reg_write[w] = cdb_q[w].reg_write;
    assign bus.CDB_value[w]     = cdb_q[w].value;
    assign bus.CDB_direction[w] = cdb_q[w].direction;
    assign bus.CDB_target[w]    = cdb_q[w].target;
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Scoreboard bench for cdb_broadcast: directed pushes, expected
// broadcasts queued with slot and cycle, monitor compares on negedge.
`timescale 1ns/1ps
module tb_cdb_broadcast;
  import cdb_broadcast_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic nuke  = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  cdb_broadcast_if bus();

  cdb_broadcast dut (
    .clock     (clk),
    .reset     (rst_n),
    .proc_nuke (nuke),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    cdb_packet_t p;
    int          slot;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  function automatic cdb_packet_t mk(input int s,
                                     input int n);
    cdb_packet_t p;
    p.ROB_idx   = ROB_W'(s * 4 + n + 8);
    p.PRN       = PRN_W'(s * 8 + n + 20);
    p.reg_write = (n % 2) == 0;
    p.value     = 32'hC0DE_0000 + 32'(s * 16 + n);
    p.direction = (s % 2) == 1;
    p.target    = 32'h0000_4000 + 32'(s * 64 + n * 4);
    return p;
  endfunction

  task automatic put(input int s, input cdb_packet_t p);
    bus.fu_valid[s]     = 1'b1;
    bus.fu_ROB_idx[s]   = p.ROB_idx;
    bus.fu_PRN[s]       = p.PRN;
    bus.fu_reg_write[s] = p.reg_write;
    bus.fu_value[s]     = p.value;
    bus.fu_direction[s] = p.direction;
    bus.fu_target[s]    = p.target;
  endtask

  task automatic idle_in();
    bus.fu_valid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input cdb_packet_t p,
                           input int slot,
                           input int c);
    exp_t e;
    e.p    = p;
    e.slot = slot;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: every valid slot must match the next expected broadcast.
  always @(negedge clk) begin
    for (int w = 0; w < CDB_WAYS; w++) begin
      cdb_packet_t a;
      exp_t        e;
      a.ROB_idx   = bus.CDB_ROB_idx[w];
      a.PRN       = bus.CDB_PRN[w];
      a.reg_write = bus.CDB_reg_write[w];
      a.value     = bus.CDB_value[w];
      a.direction = bus.CDB_direction[w];
      a.target    = bus.CDB_target[w];
      tests++;
      if (bus.CDB_valid[w]) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL cdb_unexpected: slot %0d cyc %0d pkt %h",
                   w, cyc, a);
        end else begin
          e = sb.pop_front();
          if (a !== e.p || w != e.slot || cyc != e.cyc) begin
            fails++;
            $display("FAIL cdb_pkt: got slot %0d cyc %0d pkt %h, want slot %0d cyc %0d pkt %h",
                     w, cyc, a, e.slot, e.cyc, e.p);
          end
        end
      end else if (a !== '0) begin
        fails++;
        $display("FAIL cdb_idle_zero: slot %0d pkt %h want 0",
                 w, a);
      end
    end
  end

  // Pushing into a full source is a protocol violation.
  always @(negedge clk) begin
    if (rst_n && |bus.fu_valid) begin
      tests++;
      if (|(bus.fu_valid & ~bus.fu_ready)) begin
        fails++;
        $display("FAIL protocol: fu_valid %b fu_ready %b",
                 bus.fu_valid, bus.fu_ready);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    cdb_packet_t p1;
    bus.fu_valid     = '0;
    bus.fu_ROB_idx   = '0;
    bus.fu_PRN       = '0;
    bus.fu_reg_write = '0;
    bus.fu_value     = '0;
    bus.fu_direction = '0;
    bus.fu_target    = '0;

    #1 rst_n = 1'b0;
    #11;
    check("rst_cdb_valid", 64'(bus.CDB_valid), 0);
    check("rst_cdb_value0", 64'(bus.CDB_value[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_fu_ready", 64'(bus.fu_ready), 64'hF);

    // Full contention from rr_ptr=0.
    tick();
    t = cyc;
    for (int s = 0; s < NUM_FU; s++) put(s, mk(s, 0));
    expect_at(mk(0, 0), 0, t + 2);
    expect_at(mk(1, 0), 1, t + 2);
    expect_at(mk(2, 0), 0, t + 3);
    expect_at(mk(3, 0), 1, t + 3);
    expect_at(mk(0, 1), 0, t + 4);
    expect_at(mk(1, 1), 1, t + 4);
    expect_at(mk(2, 1), 0, t + 5);
    expect_at(mk(3, 1), 1, t + 5);
    tick();
    check("t2_ready_t1", 64'(bus.fu_ready), 64'hF);
    for (int s = 0; s < NUM_FU; s++) put(s, mk(s, 1));
    tick();
    idle_in();
    check("t2_ready_t2", 64'(bus.fu_ready), 64'h3);
    tick();
    check("t2_ready_t3", 64'(bus.fu_ready), 64'hF);
    repeat (4) tick();

    // Single packet from source 2.
    t = cyc;
    p1.ROB_idx   = 5'd5;
    p1.PRN       = 6'd17;
    p1.reg_write = 1'b1;
    p1.value     = 32'hDEAD_BEEF;
    p1.direction = 1'b0;
    p1.target    = 32'h0000_1004;
    put(2, p1);
    expect_at(p1, 0, t + 2);
    tick();
    idle_in();
    check("t1_no_bypass", 64'(bus.CDB_valid), 0);
    tick();
    check("t1_valid", 64'(bus.CDB_valid), 64'h1);
    tick();
    check("t1_one_cycle", 64'(bus.CDB_valid), 0);
    tick();

    // Wrap-around from rr_ptr=3.
    t = cyc;
    put(3, mk(3, 2));
    put(0, mk(0, 2));
    expect_at(mk(3, 2), 0, t + 2);
    expect_at(mk(0, 2), 1, t + 2);
    tick();
    idle_in();
    tick();
    tick();
    // rr_ptr must now be 1.
    t = cyc;
    put(0, mk(0, 3));
    put(1, mk(1, 3));
    put(2, mk(2, 3));
    expect_at(mk(1, 3), 0, t + 2);
    expect_at(mk(2, 3), 1, t + 2);
    expect_at(mk(0, 3), 0, t + 3);
    tick();
    idle_in();
    repeat (4) tick();

    // Lone source 1 moves rr_ptr to 2.
    t = cyc;
    put(1, mk(1, 4));
    expect_at(mk(1, 4), 0, t + 2);
    tick();
    idle_in();
    repeat (3) tick();

    // Backpressure on source 1 while 2,3 hold the slots.
    t = cyc;
    for (int s = 0; s < NUM_FU; s++) put(s, mk(s, 5));
    expect_at(mk(2, 5), 0, t + 2);
    expect_at(mk(3, 5), 1, t + 2);
    expect_at(mk(0, 5), 0, t + 3);
    expect_at(mk(1, 5), 1, t + 3);
    expect_at(mk(1, 6), 0, t + 4);
    tick();
    check("t4_ready_one", 64'(bus.fu_ready[1]), 64'h1);
    idle_in();
    put(1, mk(1, 6));
    tick();
    idle_in();
    check("t4_full", 64'(bus.fu_ready), 64'hD);
    tick();
    check("t4_ready_back", 64'(bus.fu_ready[1]), 64'h1);
    repeat (4) tick();

    // Nuke with 5 queued packets and a concurrent push.
    t = cyc;
    for (int s = 0; s < NUM_FU; s++) put(s, mk(s, 7));
    expect_at(mk(2, 7), 0, t + 2);
    expect_at(mk(3, 7), 1, t + 2);
    tick();
    idle_in();
    put(1, mk(1, 8));
    put(2, mk(2, 8));
    put(3, mk(3, 8));
    tick();
    idle_in();
    check("t5_ready_pre", 64'(bus.fu_ready), 64'hD);
    put(0, mk(0, 8));
    nuke = 1'b1;
    tick();
    nuke = 1'b0;
    idle_in();
    check("t5_valid_clr", 64'(bus.CDB_valid), 0);
    check("t5_ready", 64'(bus.fu_ready), 64'hF);
    repeat (4) tick();
    // Nuke left rr_ptr at 0.
    t = cyc;
    put(3, mk(3, 9));
    put(0, mk(0, 9));
    expect_at(mk(0, 9), 0, t + 2);
    expect_at(mk(3, 9), 1, t + 2);
    tick();
    idle_in();
    repeat (3) tick();

    // Async reset while both slots are valid.
    t = cyc;
    for (int s = 0; s < NUM_FU; s++) put(s, mk(s, 10));
    expect_at(mk(0, 10), 0, t + 2);
    expect_at(mk(1, 10), 1, t + 2);
    tick();
    idle_in();
    tick();
    check("t6_pre", 64'(bus.CDB_valid), 64'h3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_drop", 64'(bus.CDB_valid), 0);
    check("t6_async_val", 64'(bus.CDB_value[1]), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_ready", 64'(bus.fu_ready), 64'hF);
    check("t6_valid", 64'(bus.CDB_valid), 0);
    repeat (5) tick();

    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
